// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith/branch ops plus
// iterative shift-add multiply and restoring divide.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       sinal_controle,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resto,
  output logic             flag,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] MUL    = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rp;

  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_resto;
  logic             sc_flag;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   div_try;
  logic [WIDTH:0]   div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic is_mul;
  logic is_div;

  assign is_mul = (sinal_controle == 4'd4);
  assign is_div = (sinal_controle == 4'd5) && (B != '0);
  assign diff   = A - B;

  always_comb begin
    sc_res   = '0;
    sc_resto = '0;
    sc_flag  = 1'b0;
    case (sinal_controle)
      4'd0: sc_res = A & B;
      4'd1: sc_res = A | B;
      4'd2: sc_res = A + B;
      4'd3: sc_res = diff;
      4'd5: begin
        // divide by zero takes the fast path
        sc_res   = '1;
        sc_resto = A;
      end
      4'd6: sc_res = B >> shamt;
      4'd7: sc_res = B << shamt;
      4'd8: sc_res = ~(A | B);
      4'd9:  sc_res = diff;
      4'd10: sc_res = diff;
      4'd11: sc_res = diff;
      4'd12: sc_res = diff;
      default: sc_res = '0;
    endcase
    case (sinal_controle)
      4'd9:  sc_flag = (A == B);
      4'd10: sc_flag = ($signed(A) < $signed(B));
      4'd11: sc_flag = ($signed(A) > $signed(B));
      4'd12: sc_flag = (A != B);
      4'd5, 4'd13, 4'd14, 4'd15: sc_flag = 1'b0;
      default: sc_flag = (sc_res == '0);
    endcase
  end

  // mul: ra=multiplicand, rb=multiplier, rp=partial product
  // div: ra=dividend/quotient, rb=divisor, rp=partial remainder
  always_comb begin
    mul_add = rb[0] ? (rp + ra) : rp;
    div_try = {rp, ra[WIDTH-1]};
    div_sub = div_try - {1'b0, rb};
    div_ok  = ~div_sub[WIDTH];
    rem_nxt = div_ok ? div_sub[WIDTH-1:0] : div_try[WIDTH-1:0];
    quo_nxt = {ra[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OCIOSO;
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      rp        <= '0;
      resultado <= '0;
      resto     <= '0;
      flag      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        OCIOSO: begin
          if (start) begin
            if (is_mul || is_div) begin
              state <= is_mul ? MUL : DIV;
              busy  <= 1'b1;
              cnt   <= CW'(WIDTH);
              ra    <= A;
              rb    <= B;
              rp    <= '0;
            end else begin
              resultado <= sc_res;
              resto     <= sc_resto;
              flag      <= sc_flag;
              done      <= 1'b1;
            end
          end
        end
        MUL: begin
          rp  <= mul_add;
          ra  <= ra << 1;
          rb  <= rb >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= OCIOSO;
            busy      <= 1'b0;
            done      <= 1'b1;
            resultado <= mul_add;
            resto     <= '0;
            flag      <= (mul_add == '0);
          end
        end
        DIV: begin
          rp  <= rem_nxt;
          ra  <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= OCIOSO;
            busy      <= 1'b0;
            done      <= 1'b1;
            resultado <= quo_nxt;
            resto     <= rem_nxt;
            flag      <= (quo_nxt == '0);
          end
        end
        default: begin
          state <= OCIOSO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
